// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment driver.
// One registered decoder is shared across all digits and is stepped by a scan prescaler.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    hex_mode,
    input  logic                    blank_lead,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    wrap;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   lead_blank;
    logic [3:0]              nib_arr   [NUM_DIGITS];
    logic                    dp_arr    [NUM_DIGITS];
    logic                    blink_arr [NUM_DIGITS];
    logic                    lead_arr  [NUM_DIGITS];

    function automatic logic [6:0] glyph_of(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = hex ? 7'b1110111 : 7'b0000000;
            4'hB: g = hex ? 7'b0011111 : 7'b0000000;
            4'hC: g = hex ? 7'b1001110 : 7'b0000000;
            4'hD: g = hex ? 7'b0111101 : 7'b0000000;
            4'hE: g = hex ? 7'b1001111 : 7'b0000000;
            default: g = hex ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    // Decode looks at the next shadow value so a load coincident with a tick shows immediately.
    always_comb begin
        digits_d   = load ? digits_in : digits_q;
        dp_sh_d    = load ? dp_in     : dp_sh_q;
        blink_sh_d = load ? blink_en  : blink_sh_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign nib_arr[gi]   = digits_d[4*gi +: 4];
            assign dp_arr[gi]    = dp_sh_d[gi];
            assign blink_arr[gi] = blink_sh_d[gi];
            assign lead_arr[gi]  = lead_blank[gi];
        end
    endgenerate

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        logic zero_run;
        lead_blank = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (nib_arr[i] == 4'd0);
            lead_blank[i] = zero_run;
        end
    end

    always_comb begin
        tick         = (presc_q == PRESC_LAST);
        wrap         = tick && (idx_q == IDX_LAST);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        frame_done_d = wrap;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        blank = (blank_lead & lead_arr[idx_d]) | (blink_arr[idx_d] & phase_q);
        seg_d = seg_q;
        dp_d  = dp_q;
        sel_d = sel_q;
        if (tick) begin
            seg_d = blank ? 7'b0000000 : glyph_of(nib_arr[idx_d], hex_mode);
            dp_d  = ~blank & dp_arr[idx_d];
            sel_d = NUM_DIGITS'(1) << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q     <= '0;
            dp_sh_q      <= '0;
            blink_sh_q   <= '0;
            presc_q      <= '0;
            idx_q        <= IDX_LAST;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            dp_sh_q      <= dp_sh_d;
            blink_sh_q   <= blink_sh_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 4-cycle scan, 2-frame blink).
// Expected tick outputs are queued ahead and compared when each scan tick lands.
module tb_seven_seg_scanner;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   digits_in;
    logic          load;
    logic [3:0]    dp_in;
    logic [3:0]    blink_en;
    logic          hex_mode;
    logic          blank_lead;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    digit_sel;
    logic          frame_done;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
        .dp_in     (dp_in),
        .blink_en  (blink_en),
        .hex_mode  (hex_mode),
        .blank_lead(blank_lead),
        .seg       (seg),
        .dp        (dp),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        int         tag;
    } exp_t;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dpv;
        logic            hex;
        logic            blank;
        logic [3:0][6:0] segs;
        logic [3:0]      dps;
    } vec_t;

    exp_t       sb[$];
    exp_t       e;
    vec_t       tbl[8];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] prev_sel = '0;
    logic [6:0] prev_seg = '0;
    logic       prev_dp  = 1'b0;

    // Cycle-accurate monitor: cyc counts edges since reset release, ticks land on multiples of SD.
    always @(posedge clk) begin
        logic rst_s;
        rst_s = rst;
        #1;
        if (rst_s) begin
            cyc = 0;
            checks++;
            if (seg !== 7'd0 || dp !== 1'b0 || digit_sel !== 4'd0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset: seg=%b dp=%b sel=%b fd=%b, expected all zero",
                         seg, dp, digit_sel, frame_done);
            end
        end else begin
            cyc++;
            if (cyc % SD == 0) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (digit_sel !== e.sel || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                        errors++;
                        $display("FAIL tick tag=%0d cyc=%0d: sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=%b",
                                 e.tag, cyc, digit_sel, seg, dp, frame_done, e.sel, e.seg, e.dp, e.fd);
                    end else begin
                        $display("tick tag=%0d cyc=%0d sel=%b seg=%b dp=%b fd=%b ok",
                                 e.tag, cyc, digit_sel, seg, dp, frame_done);
                    end
                end
            end else begin
                checks++;
                if (digit_sel !== prev_sel || seg !== prev_seg || dp !== prev_dp || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL hold cyc=%0d: sel=%b seg=%b dp=%b fd=%b, expected sel=%b seg=%b dp=%b fd=0",
                             cyc, digit_sel, seg, dp, frame_done, prev_sel, prev_seg, prev_dp);
                end
            end
        end
        prev_sel = digit_sel;
        prev_seg = seg;
        prev_dp  = dp;
    end

    task automatic push_tick(input int d, input logic [6:0] s, input logic p, input int tag);
        exp_t x;
        x.sel = 4'b0001 << d;
        x.seg = s;
        x.dp  = p;
        x.fd  = (d == 0);
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic push_frame(input logic [3:0][6:0] segs, input logic [3:0] dps, input int tag);
        for (int d = 0; d < ND; d++) push_tick(d, segs[d], dps[d], tag);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected ticks pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: cyc=%0d, required %0d", cyc, target);
        end
    endtask

    // Park at the negedge just before a wrap tick (digit 0 of a new frame).
    task automatic wait_wrap();
        int n = 0;
        while (((cyc + 1) % (SD * ND)) != SD && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0][6:0] zeros_all;
        zeros_all = {4{7'b1111110}};

        tbl[0] = '{16'h1230, 4'b0000, 1'b0, 1'b1, {7'b0110000, 7'b1101101, 7'b1111001, 7'b1111110}, 4'b0000};
        tbl[1] = '{16'h0005, 4'b0000, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1011011}, 4'b0000};
        tbl[2] = '{16'hFA9B, 4'b0000, 1'b1, 1'b0, {7'b1000111, 7'b1110111, 7'b1111011, 7'b0011111}, 4'b0000};
        tbl[3] = '{16'hFA9B, 4'b0000, 1'b0, 1'b0, {7'b0000000, 7'b0000000, 7'b1111011, 7'b0000000}, 4'b0000};
        tbl[4] = '{16'h0700, 4'b1111, 1'b0, 1'b1, {7'b0000000, 7'b1110000, 7'b1111110, 7'b1111110}, 4'b0111};
        tbl[5] = '{16'hCDE8, 4'b0101, 1'b1, 1'b0, {7'b1001110, 7'b0111101, 7'b1001111, 7'b1111111}, 4'b0101};
        tbl[6] = '{16'h0000, 4'b1111, 1'b0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0001};
        tbl[7] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000};

        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blink_en = '0;
        hex_mode = 1'b0; blank_lead = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: zero shadow shows "0" on every digit.
        push_frame(zeros_all, 4'b0000, 100);
        drain(100);

        // Table vectors, each loaded on the wrap tick so load and tick coincide.
        for (int v = 0; v < 8; v++) begin
            wait_wrap();
            digits_in  = tbl[v].digits;
            dp_in      = tbl[v].dpv;
            blink_en   = 4'b0000;
            hex_mode   = tbl[v].hex;
            blank_lead = tbl[v].blank;
            load       = 1'b1;
            push_frame(tbl[v].segs, tbl[v].dps, v);
            @(negedge clk);
            load = 1'b0;
        end
        drain(100);

        // Blink: digit 0 hidden in frames 2-3, digit 1 decimal point always on.
        do_reset();
        digits_in = 16'h0000; dp_in = 4'b0010; blink_en = 4'b0001;
        hex_mode = 1'b0; blank_lead = 1'b0; load = 1'b1;
        for (int f = 0; f < 6; f++) begin
            push_tick(0, (f == 2 || f == 3) ? 7'b0000000 : 7'b1111110, 1'b0, 200 + f);
            push_tick(1, 7'b1111110, 1'b1, 200 + f);
            push_tick(2, 7'b1111110, 1'b0, 200 + f);
            push_tick(3, 7'b1111110, 1'b0, 200 + f);
        end
        @(negedge clk);
        load = 1'b0;
        drain(400);

        // Reset mid-scan while digit 2 is selected, then the idle timing again.
        do_reset();
        digits_in = 16'h8888; dp_in = 4'b0000; blink_en = 4'b0000; load = 1'b1;
        push_tick(0, 7'b1111111, 1'b0, 300);
        push_tick(1, 7'b1111111, 1'b0, 300);
        push_tick(2, 7'b1111111, 1'b0, 300);
        @(negedge clk);
        load = 1'b0;
        wait_cyc(13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_frame(zeros_all, 4'b0000, 301);
        drain(100);

        // Load between ticks holds the old glyph until the next tick; load on a mid-frame tick shows at once.
        do_reset();
        digits_in = 16'h1111; load = 1'b1;
        push_tick(0, 7'b0110000, 1'b0, 400);
        push_tick(1, 7'b1101101, 1'b0, 400);
        push_tick(2, 7'b1111001, 1'b0, 400);
        push_tick(3, 7'b1111001, 1'b0, 400);
        @(negedge clk);
        load = 1'b0;
        wait_cyc(5);
        digits_in = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_cyc(11);
        digits_in = 16'h3333; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
